// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accepts ALU/shift/HI-LO operations over a valid/ready request port and
//   sequences them onto the datapath controls. Simple operations retire one
//   cycle after acceptance. MULTU runs a multi-cycle multiply and retires
//   through a HI/LO write-back cycle.
//
//   Optional feature macro: MUL_OVERLAP_EN
//     defined   - simple non-HI/LO ops may be accepted while a multiply runs,
//                 except in its last iteration cycle.
//     undefined - nothing is accepted while a multiply runs.
//
// Handshake: a request transfers on a rising clk edge where in_valid and
//   in_ready are both high. in_ready may depend on in_signal and is low while
//   reset is asserted. out_valid is a one-cycle strobe with no backpressure;
//   err qualifies out_valid only.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_signal, in_tag    function code and requester tag
//   alu_signal           registered function code to ALU/shifter
//   mul_start            one-cycle multiply start pulse
//   mul_count            multiplier iteration index (0 outside MUL_RUN)
//   hilo_we              one-cycle HI/LO write enable
//   out_sel              result mux: 0 ALU, 1 shifter, 2 HI, 3 LO
//   out_valid, out_tag   retire strobe and tag of retiring op
//   err                  retiring op had an illegal code
//   busy                 multiply in flight
//   state_dbg            current FSM state (0 IDLE, 1 MUL_RUN, 2 MUL_WB)
module alu_sequencer #(
   parameter int MUL_CYCLES = 32,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_signal,
   input  logic [TAG_W-1:0] in_tag,
   output logic [5:0]       alu_signal,
   output logic             mul_start,
   output logic [5:0]       mul_count,
   output logic             hilo_we,
   output logic [1:0]       out_sel,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic             err,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      MUL_WB  = 2'd2
   } state_t;

   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;

   localparam logic [5:0] LAST_COUNT = 6'(MUL_CYCLES - 1);

   state_t           state, state_n;
   logic [5:0]       alu_n, count_n;
   logic [1:0]       sel_n;
   logic [TAG_W-1:0] tag_n, mul_tag, mul_tag_n;
   logic             mul_start_n, hilo_we_n, out_valid_n, err_n;
   logic             is_known, is_multu, is_hilo, accept;
   logic [1:0]       sel_of;

   // Decode of the incoming function code.
   always_comb begin
      is_known = 1'b0;
      sel_of   = 2'd0;
      case (in_signal)
         F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULTU: is_known = 1'b1;
         F_SRL:  begin is_known = 1'b1; sel_of = 2'd1; end
         F_MFHI: begin is_known = 1'b1; sel_of = 2'd2; end
         F_MFLO: begin is_known = 1'b1; sel_of = 2'd3; end
         default: ;
      endcase
   end

   assign is_multu = (in_signal == F_MULTU);
   assign is_hilo  = (in_signal == F_MFHI) || (in_signal == F_MFLO);

   // Ready: never during reset; closed in the last multiply iteration so a
   // simple result cannot land on the write-back cycle.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (state)
            IDLE, MUL_WB: in_ready = 1'b1;
            MUL_RUN: begin
`ifdef MUL_OVERLAP_EN
               in_ready = (mul_count != LAST_COUNT) && !is_multu && !is_hilo;
`else
               in_ready = 1'b0;
`endif
            end
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept    = in_valid && in_ready;
   assign busy      = (state == MUL_RUN);
   assign state_dbg = state;

   // Next-state and registered-output logic.
   always_comb begin
      state_n     = state;
      alu_n       = alu_signal;
      sel_n       = out_sel;
      tag_n       = out_tag;
      mul_tag_n   = mul_tag;
      count_n     = 6'd0;
      mul_start_n = 1'b0;
      hilo_we_n   = 1'b0;
      out_valid_n = 1'b0;
      err_n       = 1'b0;

      case (state)
         MUL_RUN: begin
            if (mul_count == LAST_COUNT) begin
               state_n     = MUL_WB;
               hilo_we_n   = 1'b1;
               out_valid_n = 1'b1;
               tag_n       = mul_tag;
               sel_n       = 2'd2;
            end else begin
               count_n = 6'(mul_count + 6'd1);
            end
         end
         MUL_WB:  state_n = IDLE;
         default: state_n = state;
      endcase

      // in_ready guarantees an accept never coincides with the write-back
      // decision above, and MULTU is only accepted outside MUL_RUN.
      if (accept) begin
         if (is_multu) begin
            state_n     = MUL_RUN;
            mul_start_n = 1'b1;
            count_n     = 6'd0;
            mul_tag_n   = in_tag;
            alu_n       = in_signal;
         end else begin
            out_valid_n = 1'b1;
            tag_n       = in_tag;
            if (is_known) begin
               alu_n = in_signal;
               sel_n = sel_of;
            end else begin
               err_n = 1'b1;
               sel_n = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         alu_signal <= 6'd0;
         out_sel    <= 2'd0;
         out_tag    <= '0;
         mul_tag    <= '0;
         mul_count  <= 6'd0;
         mul_start  <= 1'b0;
         hilo_we    <= 1'b0;
         out_valid  <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         alu_signal <= alu_n;
         out_sel    <= sel_n;
         out_tag    <= tag_n;
         mul_tag    <= mul_tag_n;
         mul_count  <= count_n;
         mul_start  <= mul_start_n;
         hilo_we    <= hilo_we_n;
         out_valid  <= out_valid_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: simple ops, illegal code, multiply with
// HI read hold-off, op overlap (macro dependent), reset during a multiply.
module tb_alu_sequencer;

   localparam int MC    = 32;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_signal;
   logic [TAG_W-1:0] in_tag;
   logic [5:0]       alu_signal;
   logic             mul_start;
   logic [5:0]       mul_count;
   logic             hilo_we;
   logic [1:0]       out_sel;
   logic             out_valid;
   logic [TAG_W-1:0] out_tag;
   logic             err;
   logic             busy;
   logic [1:0]       state_dbg;

   int n_asserts = 0;
   int n_fail    = 0;

   alu_sequencer #(.MUL_CYCLES(MC), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_signal(in_signal), .in_tag(in_tag), .alu_signal(alu_signal),
      .mul_start(mul_start), .mul_count(mul_count), .hilo_we(hilo_we),
      .out_sel(out_sel), .out_valid(out_valid), .out_tag(out_tag),
      .err(err), .busy(busy), .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one cycle; sample #1 after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] code, input logic [TAG_W-1:0] tag);
      in_valid  = v;
      in_signal = code;
      in_tag    = tag;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_start"}, 32'(mul_start), 0);
      chk({tag, "_hilo"}, 32'(hilo_we), 0);
      chk({tag, "_ovalid"}, 32'(out_valid), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_count"}, 32'(mul_count), 0);
      chk({tag, "_alu"}, 32'(alu_signal), 0);
      chk({tag, "_sel"}, 32'(out_sel), 0);
      chk({tag, "_otag"}, 32'(out_tag), 0);
      chk({tag, "_state"}, 32'(state_dbg), 0);
   endtask

   int stray;

   initial begin
      reset = 1'b1;
      drive(1'b0, 6'd0, '0);
      repeat (2) step();
      chk_reset_vals("rst");

      reset = 1'b0;
      #1;
      chk("ready_after_rst", 32'(in_ready), 1);

      // back-to-back simple ops
      drive(1'b1, 6'd32, 4'd1);
      step();
      chk("add_valid", 32'(out_valid), 1);
      chk("add_tag", 32'(out_tag), 1);
      chk("add_sel", 32'(out_sel), 0);
      chk("add_err", 32'(err), 0);
      chk("add_alu", 32'(alu_signal), 32);
      drive(1'b1, 6'd34, 4'd2);
      step();
      chk("sub_valid", 32'(out_valid), 1);
      chk("sub_tag", 32'(out_tag), 2);
      chk("sub_sel", 32'(out_sel), 0);
      drive(1'b1, 6'd2, 4'd3);
      step();
      chk("srl_valid", 32'(out_valid), 1);
      chk("srl_tag", 32'(out_tag), 3);
      chk("srl_sel", 32'(out_sel), 1);
      chk("srl_alu", 32'(alu_signal), 2);
      drive(1'b0, 6'd0, '0);
      step();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_err", 32'(err), 0);

      // illegal code
      drive(1'b1, 6'd63, 4'd9);
      step();
      chk("ill_valid", 32'(out_valid), 1);
      chk("ill_err", 32'(err), 1);
      chk("ill_tag", 32'(out_tag), 9);
      chk("ill_start", 32'(mul_start), 0);
      chk("ill_alu_held", 32'(alu_signal), 2);
      chk("ill_busy", 32'(busy), 0);
      drive(1'b0, 6'd0, '0);
      step();
      chk("ill_err_clr", 32'(err), 0);

      // multiply with MFHI presented during it
      drive(1'b1, 6'd25, 4'd5);
      #1;
      chk("mul_ready", 32'(in_ready), 1);
      step();
      chk("mul_start", 32'(mul_start), 1);
      chk("mul_busy0", 32'(busy), 1);
      chk("mul_cnt0", 32'(mul_count), 0);
      chk("mul_state", 32'(state_dbg), 1);
      chk("mul_alu", 32'(alu_signal), 25);
      drive(1'b1, 6'd16, 4'd6);
      #1;
      chk("mfhi_held0", 32'(in_ready), 0);
      for (int k = 1; k < MC; k++) begin
         step();
         chk($sformatf("mul_cnt%0d", k), 32'(mul_count), 32'(k));
         chk($sformatf("mul_start_lo%0d", k), 32'(mul_start), 0);
         chk($sformatf("mfhi_held%0d", k), 32'(in_ready), 0);
      end
      chk("mul_busy_last", 32'(busy), 1);
      step();
      chk("wb_hilo", 32'(hilo_we), 1);
      chk("wb_valid", 32'(out_valid), 1);
      chk("wb_tag", 32'(out_tag), 5);
      chk("wb_sel", 32'(out_sel), 2);
      chk("wb_busy", 32'(busy), 0);
      chk("wb_cnt", 32'(mul_count), 0);
      chk("wb_state", 32'(state_dbg), 2);
      chk("mfhi_ready", 32'(in_ready), 1);
      step();
      chk("mfhi_valid", 32'(out_valid), 1);
      chk("mfhi_tag", 32'(out_tag), 6);
      chk("mfhi_sel", 32'(out_sel), 2);
      chk("mfhi_hilo", 32'(hilo_we), 0);
      chk("mfhi_alu", 32'(alu_signal), 16);
      drive(1'b0, 6'd0, '0);
      step();
      chk("post_state", 32'(state_dbg), 0);

      // AND presented at count 8 of a multiply
      drive(1'b1, 6'd25, 4'd5);
      step();
      drive(1'b0, 6'd0, '0);
      repeat (8) step();
      chk("ovl_cnt8", 32'(mul_count), 8);
      drive(1'b1, 6'd36, 4'd7);
`ifdef MUL_OVERLAP_EN
      #1;
      chk("ovl_ready", 32'(in_ready), 1);
      step();
      chk("ovl_valid", 32'(out_valid), 1);
      chk("ovl_tag", 32'(out_tag), 7);
      chk("ovl_busy", 32'(busy), 1);
      drive(1'b0, 6'd0, '0);
      repeat (MC - 9) step();
`else
      #1;
      chk("ovl_ready", 32'(in_ready), 0);
      repeat (MC - 8) step();
`endif
      chk("ovl_wb_hilo", 32'(hilo_we), 1);
      chk("ovl_wb_valid", 32'(out_valid), 1);
      chk("ovl_wb_tag", 32'(out_tag), 5);
`ifndef MUL_OVERLAP_EN
      chk("ovl_and_ready", 32'(in_ready), 1);
      step();
      chk("ovl_and_valid", 32'(out_valid), 1);
      chk("ovl_and_tag", 32'(out_tag), 7);
      chk("ovl_and_sel", 32'(out_sel), 0);
      drive(1'b0, 6'd0, '0);
`endif
      step();

      // reset during a multiply
      drive(1'b1, 6'd25, 4'd5);
      step();
      drive(1'b0, 6'd0, '0);
      repeat (5) step();
      chk("pre_rst_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      step();
      reset = 1'b0;
      #1;
      chk("rel_ready", 32'(in_ready), 1);
      stray = 0;
      repeat (MC + 3) begin
         step();
         if (hilo_we || out_valid || busy) stray++;
      end
      chk("no_stray_retire", 32'(stray), 0);

      drive(1'b1, 6'd25, 4'd11);
      step();
      chk("mul2_start", 32'(mul_start), 1);
      drive(1'b0, 6'd0, '0);
      repeat (MC) step();
      chk("mul2_hilo", 32'(hilo_we), 1);
      chk("mul2_tag", 32'(out_tag), 11);
      chk("mul2_valid", 32'(out_valid), 1);
      step();
      chk("mul2_done", 32'(hilo_we), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
